// File: rtl/ysyx_24100006_ifu_ctrl_if.sv
// Instruction-fetch read channel between the IFU controller and the memory bus.
// The controller is the master; the memory side is the slave.
interface ysyx_24100006_ifu_ctrl_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ysyx_24100006_ifu_ctrl.sv
// Single-outstanding instruction fetch controller: issues a read for pc, hands the
// instruction to decode, then waits for the next PC or raises an access/timeout fault.
module ysyx_24100006_ifu_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [31:0]                     pc,
  input  logic                            npc_valid,
  output logic                            pcw,
  output logic [1:0]                      access_fault,
  ysyx_24100006_ifu_ctrl_if.master        bus,
  output logic                            inst_valid,
  input  logic                            inst_ready,
  output logic [31:0]                     inst,
  output logic [31:0]                     inst_pc,
  output logic [31:0]                     fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_EXEC, S_FAULT
  } state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_rsp_t;

  localparam logic [1:0]  F_NONE    = 2'b00;
  localparam logic [1:0]  F_ACCESS  = 2'b01;
  localparam logic [1:0]  F_TIMEOUT = 2'b10;
  // Counter value seen during the TIMEOUT-th cycle of REQ plus WAIT.
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [31:0] tmo_q, tmo_d;
  logic [1:0]  fault_q, fault_d;
  fetch_rsp_t  rsp_q, rsp_d;
  logic [31:0] cnt_q, cnt_d;

  logic arvalid, rready, tmo_expire;

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    fault_d      = fault_q;
    rsp_d        = rsp_q;
    cnt_d        = cnt_q;
    arvalid      = 1'b0;
    rready       = 1'b0;
    inst_valid   = 1'b0;
    pcw          = 1'b0;
    access_fault = F_NONE;
    tmo_expire   = (tmo_q >= TMO_LAST);

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (pc[1:0] != 2'b00) begin
          fault_d = F_ACCESS;
          state_d = S_FAULT;
        end else begin
          arvalid = 1'b1;
          // A handshake landing on the last allowed cycle wins over the timeout.
          if (bus.arready) begin
            state_d = S_WAIT;
          end else if (tmo_expire) begin
            fault_d = F_TIMEOUT;
            state_d = S_FAULT;
          end
        end
      end
      S_WAIT: begin
        rready = 1'b1;
        if (bus.rvalid) begin
          if (bus.rresp != 2'b00) begin
            fault_d = F_ACCESS;
            state_d = S_FAULT;
          end else begin
            rsp_d   = '{inst: bus.rdata, pc: pc};
            state_d = S_HOLD;
          end
        end else if (tmo_expire) begin
          fault_d = F_TIMEOUT;
          state_d = S_FAULT;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (npc_valid) begin
          pcw     = 1'b1;
          state_d = S_REQ;
        end
      end
      S_FAULT: begin
        pcw          = 1'b1;
        access_fault = fault_q;
        fault_d      = F_NONE;
        state_d      = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_REQ || state_q == S_WAIT)
      tmo_d = (tmo_q == 32'hffff_ffff) ? tmo_q : tmo_q + 32'd1;
    if (state_d == S_REQ && state_q != S_REQ)
      tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      fault_q <= F_NONE;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  // pc is only rewritten by pcw, which never fires while a request is open.
  assign bus.arvalid = arvalid;
  assign bus.araddr  = arvalid ? pc : 32'd0;
  assign bus.rready  = rready;
  assign inst        = rsp_q.inst;
  assign inst_pc     = rsp_q.pc;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_ysyx_24100006_ifu_ctrl.sv
// Bench for the IFU fetch controller: table of directed fetches, reset corner cases,
// then randomized fetches checked against a cycle-count reference model.
module tb_ysyx_24100006_ifu_ctrl;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        npc_valid;
  logic        pcw;
  logic [1:0]  access_fault;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst, inst_pc, fetch_cnt;

  ysyx_24100006_ifu_ctrl_if bus ();

  ysyx_24100006_ifu_ctrl #(.TIMEOUT(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .npc_valid    (npc_valid),
    .pcw          (pcw),
    .access_fault (access_fault),
    .bus          (bus),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          ar_dly;
    int          rv_dly;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    int          ir_dly;
    int          npc_dly;
    bit          noise;
    logic [1:0]  exp_code;
    int          exp_pcw;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_cnt = 0;
  vec_t        tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle numbers count from 1 = first REQ cycle. AR handshake at cycle a,
  // R beat at cycle c. A timeout fires on the first cycle >= T that completes nothing.
  function automatic void predict(input vec_t v, output logic [1:0] code, output int pcw_cyc);
    int a, c;
    a = v.ar_dly + 1;
    c = a + v.rv_dly + 1;
    if (v.pc[1:0] != 2'b00) begin code = 2'b01; pcw_cyc = 2; return; end
    for (int k = T; k < c; k++)
      if (k != a) begin code = 2'b10; pcw_cyc = k + 1; return; end
    if (v.rresp != 2'b00) begin code = 2'b01; pcw_cyc = c + 1; return; end
    code    = 2'b00;
    pcw_cyc = c + 2 + v.ir_dly + v.npc_dly;
  endfunction

  // Entered at posedge+1 of the first REQ cycle; returns at posedge+1 of the next REQ.
  task automatic run_fetch(input vec_t v, input string tag, input logic [1:0] ecode, input int ecyc);
    int cyc = 0, nar = 0, nwait = 0, nhold = 0, nexec = 0;
    int pcw_n = 0, pcw_cyc = -1, inst_cyc = -1, bad = 0;
    bit ar_done = 0, in_exec = 0;
    logic [1:0] af = 2'b00;
    pc = v.pc;
    bus.rdata = v.rdata;
    bus.rresp = v.rresp;
    while (pcw_n == 0 && cyc < 300) begin
      cyc++;
      bus.arready = (nar >= v.ar_dly);
      bus.rvalid  = ar_done ? (nwait >= v.rv_dly) : v.noise;
      inst_ready  = (nhold >= v.ir_dly);
      npc_valid   = in_exec ? (nexec >= v.npc_dly) : (v.noise && cyc <= 2);
      @(negedge clk);
      if (int'(bus.arvalid) + int'(bus.rready) + int'(inst_valid) > 1) bad++;
      if (bus.arvalid && (bus.araddr !== v.pc || v.pc[1:0] != 2'b00)) bad++;
      if (!pcw && access_fault !== 2'b00) bad++;
      if (inst_valid && (inst !== v.rdata || inst_pc !== v.pc)) bad++;
      if (inst_valid && inst_cyc < 0) inst_cyc = cyc;
      if (pcw) begin pcw_n++; pcw_cyc = cyc; af = access_fault; end
      if (bus.arvalid) begin nar++; if (bus.arready) ar_done = 1; end
      if (bus.rready) nwait++;
      if (in_exec) nexec++;
      if (inst_valid) begin nhold++; if (inst_ready) in_exec = 1; end
      @(posedge clk);
      #1;
    end
    npc_valid = 1'b0;
    check({tag, " pcw_seen"}, 64'(pcw_n), 64'd1);
    check({tag, " code"}, 64'(af), 64'(ecode));
    check({tag, " pcw_cyc"}, 64'(pcw_cyc), 64'(ecyc));
    if (ecode == 2'b00) begin
      model_cnt++;
      check({tag, " inst_cyc"}, 64'(inst_cyc), 64'(v.ar_dly + v.rv_dly + 3));
    end else begin
      check({tag, " no_inst"}, 64'(inst_cyc), 64'(-1));
    end
    check({tag, " fetch_cnt"}, 64'(fetch_cnt), 64'(model_cnt));
    check({tag, " invariants"}, 64'(bad), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.arready = 1'b0; bus.rvalid = 1'b0; inst_ready = 1'b0; npc_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_cnt = 0;
  endtask

  task automatic check_zero(input string name);
    check({name, " ctl"}, 64'({bus.arvalid, bus.rready, inst_valid, pcw, access_fault}), 64'd0);
    check({name, " data"}, 64'(bus.araddr | inst | inst_pc | fetch_cnt), 64'd0);
  endtask

  initial begin
    vec_t v;
    logic [1:0] ec;
    int ecyc;
    //             pc            ar rv rresp  rdata         ir npc noise code   pcw
    tbl[0] = '{32'h3000_0000,  0, 0, 2'b00, 32'h0000_0013, 0, 0, 0, 2'b00,  4};
    tbl[1] = '{32'h3000_0004,  3, 1, 2'b00, 32'hdead_beef, 4, 2, 1, 2'b00, 14};
    tbl[2] = '{32'h3000_0008,  0, 0, 2'b10, 32'h1111_1111, 0, 0, 0, 2'b01,  3};
    tbl[3] = '{32'h3000_000c, 20, 0, 2'b00, 32'h2222_2222, 0, 0, 0, 2'b10,  9};
    tbl[4] = '{32'h3000_0010,  7, 0, 2'b00, 32'h3333_3333, 0, 0, 0, 2'b00, 11};
    tbl[5] = '{32'h3000_0002,  0, 0, 2'b00, 32'h4444_4444, 0, 0, 1, 2'b01,  2};
    tbl[6] = '{32'h3000_0014,  2, 5, 2'b00, 32'h5555_5555, 0, 0, 0, 2'b10,  9};
    tbl[7] = '{32'h3000_0018,  1, 5, 2'b00, 32'h6666_6666, 1, 0, 0, 2'b00, 11};

    pc = 32'h3000_0000; bus.rdata = 32'd0; bus.rresp = 2'b00;
    do_reset();
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h1234_5678;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++)
      run_fetch(tbl[i], $sformatf("tbl%0d", i), tbl[i].exp_code, tbl[i].exp_pcw);

    // Reset while the read beat is outstanding; a late rvalid must be dropped.
    pc = 32'h3000_0040; bus.arready = 1'b1; bus.rvalid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("wait rready", 64'(bus.rready), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hbad0_bad0; model_cnt = 0;
    @(negedge clk);
    check_zero("rst_wait");
    @(posedge clk);
    #1;
    v = '{32'h3000_0044, 0, 0, 2'b00, 32'h0000_0093, 0, 0, 0, 2'b00, 0};
    predict(v, ec, ecyc);
    run_fetch(v, "post_rst", ec, ecyc);

    for (int i = 0; i < 40; i++) begin
      v.pc      = 32'h3000_0000 + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 7) == 0) v.pc[1:0] = 2'($urandom_range(1, 3));
      v.ar_dly  = $urandom_range(0, 9);
      v.rv_dly  = $urandom_range(0, 6);
      v.rresp   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.rdata   = $urandom;
      v.ir_dly  = $urandom_range(0, 4);
      v.npc_dly = $urandom_range(0, 3);
      v.noise   = 1'($urandom_range(0, 1));
      predict(v, ec, ecyc);
      run_fetch(v, $sformatf("rnd%0d", i), ec, ecyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
